// File: rtl/psum_drain.sv
// psum_drain: snapshots one row of PE accumulators, clears them, and streams
// rounded / ReLU'd / saturated 12-bit results over a valid/ready port.
`default_nettype none

module psum_drain #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [20*N-1:0]   acc_in,
  input  logic [3:0]        shift,
  input  logic              relu_en,
  output logic              pe_clr,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [11:0]       out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t             state;
  logic signed [19:0] shadow [N];
  logic [IDX_W-1:0]   idx;
  logic [3:0]         shift_q;
  logic               relu_q;

  logic               xfer;
  logic signed [20:0] sel_ext;
  logic signed [20:0] rnd;
  logic signed [20:0] shifted;
  logic signed [20:0] clipped;

  assign xfer = (state == DRAIN) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      pe_clr  <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < N; i++) shadow[i] <= '0;
    end else begin
      pe_clr <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) shadow[i] <= acc_in[20*i +: 20];
            shift_q <= shift;
            relu_q  <= relu_en;
            idx     <= '0;
            pe_clr  <= 1'b1;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // 21-bit datapath: the largest rounding offset added to a 20-bit value cannot overflow.
  always_comb begin
    sel_ext = {shadow[idx][19], shadow[idx]};
    rnd     = '0;
    if (shift_q != 4'd0) rnd = 21'sd1 <<< (shift_q - 4'd1);
    shifted = (sel_ext + rnd) >>> shift_q;
    clipped = shifted;
    if (relu_q && shifted < 0) clipped = '0;
    if (clipped > 21'sd2047)       out_data = 12'h7ff;
    else if (clipped < -21'sd2048) out_data = 12'h800;
    else                           out_data = clipped[11:0];
  end

  assign busy      = (state == DRAIN);
  assign out_valid = (state == DRAIN);
  assign out_idx   = idx;
  assign out_last  = (state == DRAIN) && (idx == LAST_IDX);

endmodule

`default_nettype wire

// File: tb/tb_psum_drain.sv
// Directed self-checking bench for psum_drain (N=4).
`default_nettype none

module tb_psum_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [79:0] acc_in;
  logic [3:0]  shift;
  logic        relu_en;
  logic        pe_clr;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        done;

  int checks = 0;
  int errors = 0;

  psum_drain #(.N(4), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .acc_in(acc_in), .shift(shift),
    .relu_en(relu_en), .pe_clr(pe_clr), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] pack(input int a0, input int a1, input int a2, input int a3);
    logic [19:0] l0, l1, l2, l3;
    l0 = 20'(a0); l1 = 20'(a1); l2 = 20'(a2); l3 = 20'(a3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_data"}, int'(out_data), 0);
    chk({tag, " out_idx"}, int'(out_idx), 0);
    chk({tag, " out_last"}, out_last, 0);
    chk({tag, " pe_clr"}, pe_clr, 0);
    chk({tag, " done"}, done, 0);
  endtask

  // Drives start for one edge; returns at T+1 (+1ns).
  task automatic issue_start(input logic [79:0] acc, input logic [3:0] sh, input logic relu);
    acc_in = acc; shift = sh; relu_en = relu; start = 1'b1;
    step();
    start = 1'b0;
    acc_in = pack(111, 222, 333, 444);
  endtask

  task automatic drain_ready(input string tag, input int e0, input int e1, input int e2, input int e3);
    int ev[4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s valid%0d", tag, k), out_valid, 1);
      chk($sformatf("%s busy%0d", tag, k), busy, 1);
      chk($sformatf("%s idx%0d", tag, k), int'(out_idx), k);
      chk($sformatf("%s data%0d", tag, k), int'($signed(out_data)), ev[k]);
      chk($sformatf("%s last%0d", tag, k), out_last, (k == 3) ? 1 : 0);
      chk($sformatf("%s pe_clr%0d", tag, k), pe_clr, (k == 0) ? 1 : 0);
      chk($sformatf("%s done%0d", tag, k), done, 0);
      step();
    end
    chk({tag, " done_pulse"}, done, 1);
    chk({tag, " busy_end"}, busy, 0);
    chk({tag, " valid_end"}, out_valid, 0);
    step();
    chk({tag, " done_one_cycle"}, done, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; acc_in = '0; shift = '0; relu_en = 1'b0; out_ready = 1'b0;
    step(); step();
    chk_idle_outputs("reset");
    rst = 1'b0;
    step();
    chk_idle_outputs("post_reset");
  endtask

  task automatic test_basic();
    issue_start(pack(1000, -1000, 5, 0), 4'd0, 1'b0);
    drain_ready("basic", 1000, -1000, 5, 0);
  endtask

  task automatic test_rounding();
    issue_start(pack(3, -5, 4096, -4097), 4'd1, 1'b0);
    drain_ready("round", 2, -2, 2047, -2048);
    issue_start(pack(-24, 24, 40, 1000), 4'd4, 1'b0);
    drain_ready("shift4", -1, 2, 3, 63);
  endtask

  task automatic test_relu();
    issue_start(pack(-1, 524287, -524288, 7), 4'd0, 1'b1);
    drain_ready("relu", 0, 2047, 0, 7);
  endtask

  task automatic test_back_to_back();
    // start presented in the same cycle done is high must be accepted.
    issue_start(pack(1, 2, 3, 4), 4'd0, 1'b0);
    out_ready = 1'b1;
    step(); step(); step(); step();
    chk("b2b done", done, 1);
    issue_start(pack(10, 20, 30, 40), 4'd0, 1'b0);
    drain_ready("b2b", 10, 20, 30, 40);
  endtask

  task automatic test_backpressure();
    int ev[4];
    int rdy[7];
    int k;
    ev = '{9, -9, 100, -100};
    rdy = '{1, 0, 0, 1, 0, 1, 1};
    k = 0;
    issue_start(pack(9, -9, 100, -100), 4'd0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      out_ready = rdy[c][0];
      chk($sformatf("bp valid c%0d", c), out_valid, 1);
      chk($sformatf("bp idx c%0d", c), int'(out_idx), k);
      chk($sformatf("bp data c%0d", c), int'($signed(out_data)), ev[k]);
      chk($sformatf("bp last c%0d", c), out_last, (k == 3) ? 1 : 0);
      chk($sformatf("bp done c%0d", c), done, 0);
      step();
      if (rdy[c] == 1) k++;
    end
    chk("bp lanes", k, 4);
    chk("bp done", done, 1);
    chk("bp valid_end", out_valid, 0);
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_start_while_busy();
    int ev[4];
    ev = '{50, -60, 70, -80};
    issue_start(pack(50, -60, 70, -80), 4'd0, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("swb idx%0d", k), int'(out_idx), k);
      chk($sformatf("swb data%0d", k), int'($signed(out_data)), ev[k]);
      chk($sformatf("swb pe_clr%0d", k), pe_clr, (k == 0) ? 1 : 0);
      if (k == 1) begin
        start = 1'b1; acc_in = pack(1, 1, 1, 1); shift = 4'd3; relu_en = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    chk("swb done", done, 1);
    step();
    chk("swb not_restarted", busy, 0);
    chk("swb no_pe_clr", pe_clr, 0);
  endtask

  task automatic test_reset_mid_drain();
    int done_seen;
    issue_start(pack(-300, 301, 302, 303), 4'd0, 1'b0);
    out_ready = 1'b1;
    step();
    chk("rmd beat1 idx", int'(out_idx), 1);
    rst = 1'b1;
    step();
    chk_idle_outputs("rmd");
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (done === 1'b1 || busy === 1'b1 || pe_clr === 1'b1) done_seen = 1;
      step();
    end
    chk("rmd quiet_after_reset", done_seen, 0);
    issue_start(pack(-7, 8, -9, 10), 4'd0, 1'b1);
    drain_ready("rmd_restart", 0, 8, 0, 10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_relu();
    test_back_to_back();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
